// File: rtl/jk_sync_counter.sv
// Modulo-MOD up/down counter built from WIDTH JK state cells driven in toggle form.
// Supports a saturating synchronous load, a combinational terminal count and a registered wrap pulse.
module jk_sync_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             wrap
);

  // The modulus may equal 2**WIDTH, so comparisons against it need one extra bit.
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] nxt;
  logic             illegal;

  assign illegal = ({1'b0, q} >= MOD_EXT);

  always_comb begin
    nxt = q;
    if (load) begin
      nxt = ({1'b0, din} < MOD_EXT) ? din : LAST;
    end else if (en) begin
      if (illegal)
        nxt = '0;
      else if (up)
        nxt = (q == LAST) ? '0 : q + WIDTH'(1);
      else
        nxt = (q == '0) ? LAST : q - WIDTH'(1);
    end
  end

  // Toggle-form excitation: a cell toggles exactly where q and nxt differ.
  assign j_vec = q ^ nxt;
  assign k_vec = q ^ nxt;

  assign tc = en & ~load & ((up & (q == LAST)) | (~up & (q == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j_vec[i], k_vec[i]})
          2'b01:   q[i] <= 1'b0;
          2'b10:   q[i] <= 1'b1;
          2'b11:   q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wrap <= 1'b0;
    else
      wrap <= tc;
  end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench for jk_sync_counter (WIDTH=4, MOD=10): expected results are queued as stimulus
// is driven and popped after the clock edge that should produce them.
module tb_jk_sync_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst_n, en, up, load, tc, wrap;
  logic [W-1:0] din, q, j_vec, k_vec;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic         wrap;
  } exp_t;

  typedef struct packed {
    logic         e;
    logic         u;
    logic         l;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
  } row_t;

  exp_t sb[$];
  exp_t want;

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(W), .MOD(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .up    (up),
    .load  (load),
    .din   (din),
    .q     (q),
    .j_vec (j_vec),
    .k_vec (k_vec),
    .tc    (tc),
    .wrap  (wrap)
  );

  task automatic drive(input logic e, input logic u, input logic l, input logic [W-1:0] d);
    @(negedge clk);
    en = e; up = u; load = l; din = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (q !== 4'd0) begin failures++; $display("[TB] FAIL reset_q got=%0d exp=0", q); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (tc !== 1'b0) begin failures++; $display("[TB] FAIL reset_tc_idle got=%b exp=0", tc); end
    en = 1'b1; up = 1'b1; #1;
    checks++; if (tc !== 1'b0) begin failures++; $display("[TB] FAIL reset_tc_up got=%b exp=0", tc); end
    checks++; if (j_vec !== 4'b0001) begin failures++; $display("[TB] FAIL reset_j_up got=%b exp=0001", j_vec); end
    up = 1'b0; #1;
    checks++; if (tc !== 1'b1) begin failures++; $display("[TB] FAIL reset_tc_down got=%b exp=1", tc); end
    checks++; if (j_vec !== 4'b1001 || k_vec !== 4'b1001) begin
      failures++; $display("[TB] FAIL reset_jk_down got=%b/%b exp=1001/1001", j_vec, k_vec);
    end
    tick();
    checks++; if (q !== 4'd0) begin failures++; $display("[TB] FAIL reset_hold_q got=%0d exp=0", q); end
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    rst_n = 1'b1;
    sb.push_back('{4'd0, 1'b0});
    tick();
    want = sb.pop_front();
    checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL release_q got=%0d exp=%0d", q, want.q); end
  endtask

  task automatic test_up_count();
    int seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int prev = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd0);
      #1;
      checks++; if (tc !== (prev == 9)) begin failures++; $display("[TB] FAIL up_tc[%0d] got=%b exp=%b", i, tc, prev == 9); end
      sb.push_back('{W'(seq[i]), prev == 9});
      tick();
      want = sb.pop_front();
      checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL up_q[%0d] got=%0d exp=%0d", i, q, want.q); end
      checks++; if (wrap !== want.wrap) begin failures++; $display("[TB] FAIL up_wrap[%0d] got=%b exp=%b", i, wrap, want.wrap); end
      prev = seq[i];
    end
  endtask

  task automatic test_down_count();
    row_t rows[5] = '{
      '{1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0}
    };
    for (int i = 0; i < 5; i++) begin
      drive(rows[i].e, rows[i].u, rows[i].l, rows[i].d);
      #1;
      checks++; if (tc !== rows[i].tc) begin failures++; $display("[TB] FAIL down_tc[%0d] got=%b exp=%b", i, tc, rows[i].tc); end
      sb.push_back('{rows[i].q, rows[i].wrap});
      tick();
      want = sb.pop_front();
      checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL down_q[%0d] got=%0d exp=%0d", i, q, want.q); end
      checks++; if (wrap !== want.wrap) begin failures++; $display("[TB] FAIL down_wrap[%0d] got=%b exp=%b", i, wrap, want.wrap); end
    end
  endtask

  task automatic test_load_saturate();
    row_t rows[4] = '{
      '{1'b1, 1'b1, 1'b1, 4'd13, 4'd9, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 4'd4,  4'd4, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b1, 4'd10, 4'd9, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 4'd15, 4'd9, 1'b0, 1'b0}
    };
    for (int i = 0; i < 4; i++) begin
      drive(rows[i].e, rows[i].u, rows[i].l, rows[i].d);
      #1;
      checks++; if (tc !== rows[i].tc) begin failures++; $display("[TB] FAIL load_tc[%0d] got=%b exp=%b", i, tc, rows[i].tc); end
      if (i == 0) begin
        checks++; if (j_vec !== 4'b0001) begin failures++; $display("[TB] FAIL load_j_sat got=%b exp=0001", j_vec); end
      end
      sb.push_back('{rows[i].q, rows[i].wrap});
      tick();
      want = sb.pop_front();
      checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL load_q[%0d] got=%0d exp=%0d", i, q, want.q); end
      checks++; if (wrap !== want.wrap) begin failures++; $display("[TB] FAIL load_wrap[%0d] got=%b exp=%b", i, wrap, want.wrap); end
    end
  endtask

  task automatic test_excitation();
    drive(1'b0, 1'b1, 1'b1, 4'd7);
    sb.push_back('{4'd7, 1'b0});
    tick();
    want = sb.pop_front();
    checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL exc_load_q got=%0d exp=%0d", q, want.q); end
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    #1;
    checks++; if (j_vec !== 4'b1111 || k_vec !== 4'b1111) begin
      failures++; $display("[TB] FAIL exc_jk_count got=%b/%b exp=1111/1111", j_vec, k_vec);
    end
    sb.push_back('{4'd8, 1'b0});
    tick();
    want = sb.pop_front();
    checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL exc_count_q got=%0d exp=%0d", q, want.q); end
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    checks++; if (j_vec !== 4'b0000 || k_vec !== 4'b0000) begin
      failures++; $display("[TB] FAIL exc_jk_hold got=%b/%b exp=0000/0000", j_vec, k_vec);
    end
    sb.push_back('{4'd8, 1'b0});
    tick();
    want = sb.pop_front();
    checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL exc_hold_q got=%0d exp=%0d", q, want.q); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b1, 4'd6);
    sb.push_back('{4'd6, 1'b0});
    tick();
    want = sb.pop_front();
    checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL ar_load_q got=%0d exp=%0d", q, want.q); end
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q !== 4'd0) begin failures++; $display("[TB] FAIL ar_mid_q got=%0d exp=0", q); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("[TB] FAIL ar_mid_wrap got=%b exp=0", wrap); end
    tick();
    checks++; if (q !== 4'd0) begin failures++; $display("[TB] FAIL ar_held_q got=%0d exp=0", q); end
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    rst_n = 1'b1;
    sb.push_back('{4'd1, 1'b0});
    tick();
    want = sb.pop_front();
    checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL ar_resume_q got=%0d exp=%0d", q, want.q); end
    // Get wrap high, then show reset clears it without a clock edge.
    drive(1'b0, 1'b1, 1'b1, 4'd9);
    sb.push_back('{4'd9, 1'b0});
    tick();
    want = sb.pop_front();
    checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL ar_load9_q got=%0d exp=%0d", q, want.q); end
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    sb.push_back('{4'd0, 1'b1});
    tick();
    want = sb.pop_front();
    checks++; if (wrap !== want.wrap) begin failures++; $display("[TB] FAIL ar_wrap_set got=%b exp=%b", wrap, want.wrap); end
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wrap !== 1'b0) begin failures++; $display("[TB] FAIL ar_wrap_clear got=%b exp=0", wrap); end
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    rst_n = 1'b1;
  endtask

  task automatic test_direction_flip();
    row_t rows[6] = '{
      '{1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      drive(rows[i].e, rows[i].u, rows[i].l, rows[i].d);
      #1;
      checks++; if (tc !== rows[i].tc) begin failures++; $display("[TB] FAIL flip_tc[%0d] got=%b exp=%b", i, tc, rows[i].tc); end
      sb.push_back('{rows[i].q, rows[i].wrap});
      tick();
      want = sb.pop_front();
      checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL flip_q[%0d] got=%0d exp=%0d", i, q, want.q); end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[5] = '{
      '{1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0}
    };
    for (int i = 0; i < 5; i++) begin
      drive(rows[i].e, rows[i].u, rows[i].l, rows[i].d);
      #1;
      checks++; if (tc !== rows[i].tc) begin failures++; $display("[TB] FAIL b2b_tc[%0d] got=%b exp=%b", i, tc, rows[i].tc); end
      sb.push_back('{rows[i].q, rows[i].wrap});
      tick();
      want = sb.pop_front();
      checks++; if (q !== want.q) begin failures++; $display("[TB] FAIL b2b_q[%0d] got=%0d exp=%0d", i, q, want.q); end
      checks++; if (wrap !== want.wrap) begin failures++; $display("[TB] FAIL b2b_wrap[%0d] got=%b exp=%b", i, wrap, want.wrap); end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_load_saturate();
    test_excitation();
    test_async_reset();
    test_direction_flip();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/jk_sync_counter.md
JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 SHALL have parameter MOD, default 10: count modulus; legal range 2 <= MOD <= 2**WIDTH.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port load  input  1  synchronous parallel load.
REQ-008 SHALL have port din  input  WIDTH  load value.
REQ-009 SHALL have port q  output  WIDTH  current count, taken from the JK state cells.
REQ-010 SHALL have port j_vec  output  WIDTH  J excitation presented to each state cell (combinational).
REQ-011 SHALL have port k_vec  output  WIDTH  K excitation presented to each state cell (combinational).
REQ-012 SHALL have port tc  output  1  terminal count (combinational).
REQ-013 SHALL have port wrap  output  1  registered single-cycle wrap pulse.

Function
REQ-014 SHALL hold state in WIDTH JK cells. On each rising clk edge, cell i SHALL apply standard JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-015 SHALL compute a next-state vector nxt each cycle and drive j_vec = k_vec = q ^ nxt (toggle-form excitation); no other path SHALL alter q except reset.
REQ-016 Priority SHALL be load > en > hold.
REQ-017 load=1: nxt = din if din < MOD, else nxt = MOD-1 (saturate); en and up are ignored.
REQ-018 load=0, en=1, up=1: nxt = q+1, or 0 when q == MOD-1.
REQ-019 load=0, en=1, up=0: nxt = q-1, or MOD-1 when q == 0.
REQ-020 load=0, en=0: nxt = q, so j_vec = k_vec = 0.
REQ-021 If q >= MOD (illegal state), load=0 and en=1: nxt = 0 regardless of up.
REQ-022 tc SHALL equal en & ~load & ((up & q == MOD-1) | (~up & q == 0)).
REQ-023 wrap SHALL be registered and high for exactly the one cycle after an edge at which tc was 1; otherwise 0.
REQ-024 Latency: q reflects a load or count on the same rising edge at which load or en is sampled high; no added pipeline stage.
REQ-025 A direction change mid-sequence SHALL take effect at the next enabled edge with no skipped or repeated value.
REQ-026 All arithmetic SHALL be WIDTH bits, with wrap-around governed only by MOD, never by natural 2**WIDTH overflow when MOD < 2**WIDTH.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force q = 0 and wrap = 0.
REQ-028 While rst_n=0, j_vec, k_vec and tc SHALL track the combinational rules against q = 0.
REQ-029 Deassertion of rst_n SHALL take effect at the first rising clk edge after it; a reset asserted mid-count SHALL abort the count with no partial update.

Verification (WIDTH=4, MOD=10)
REQ-030 Up count: reset, then en=1, up=1 for 12 edges -> q = 1..9,0,1,2; tc high while q=9; wrap high for the one cycle with q=0.
REQ-031 Down count: load din=2, then en=1, up=0 -> q = 2,1,0,9,8; tc high while q=0; wrap follows the transition to 9.
REQ-032 Load priority and saturation: load=1 with en=1 and din=13 -> q = 9 and tc = 0 during load; next load din=4 -> q = 4.
REQ-033 Excitation check: q=7, en=1, up=1 -> j_vec = k_vec = 4'b1111; en=0 -> j_vec = k_vec = 0 and q holds.
REQ-034 Asynchronous reset: rst_n pulled low between edges at q=6 -> q = 0 and wrap = 0 before the next edge; count resumes from 0 after release.
REQ-035 Direction flip: up count to 5, switch up=0 -> q = 4,3; switch back up=1 -> q = 4.
